// File: rtl/pong_pkg.sv
// Shared Pong definitions: ball FSM states, direction encodings and the
// screen bounds also used by the collision and win detectors.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_HOLD
    } ball_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCREEN_X_MIN = 0;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MIN = 0;
    localparam int unsigned SCREEN_Y_MAX = 479;

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: next position and direction for a single frame.
// A forced flip (paddle) reverses direction and steps in the new direction,
// taking precedence over the wall checks. The low wall clamps to MIN; the
// high wall (optional) clamps to MAX-SIZE. Upward steps saturate rather
// than wrap.
module ball_axis_step
    import pong_pkg::*;
#(
    parameter int unsigned STEP   = 1,
    parameter int unsigned MIN    = 0,
    parameter int unsigned MAX    = 479,
    parameter int unsigned SIZE   = 8,
    parameter bit          MAX_EN = 1'b1
) (
    input  logic [COORD_W-1:0] i_pos,
    input  dir_t               i_dir,
    input  logic               i_force_flip,
    output logic [COORD_W-1:0] o_pos,
    output dir_t               o_dir
);

    localparam int unsigned EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0]   L_STEP_EXT = EXT_W'(STEP);
    localparam logic [EXT_W-1:0]   L_MIN_EXT  = EXT_W'(MIN);
    localparam logic [EXT_W-1:0]   L_MAX_EXT  = EXT_W'(MAX);
    localparam logic [EXT_W-1:0]   L_SIZE_EXT = EXT_W'(SIZE);
    localparam logic [COORD_W-1:0] L_STEP_C   = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] L_MIN_C    = COORD_W'(MIN);
    localparam logic [COORD_W-1:0] L_BOUNCE_C = COORD_W'(MAX - SIZE);

    logic [EXT_W-1:0]   w_pos;
    logic [EXT_W-1:0]   w_inc;
    logic [COORD_W-1:0] w_dec;
    dir_t               w_dir_eff;
    logic               w_at_min;
    logic               w_at_max;

    // Next position/direction; all bound comparisons use the widened value.
    always_comb begin
        w_pos     = {1'b0, i_pos};
        w_inc     = w_pos + L_STEP_EXT;
        w_dec     = i_pos - L_STEP_C;
        w_dir_eff = i_force_flip ? ((i_dir == DIR_POS) ? DIR_NEG : DIR_POS) : i_dir;
        w_at_min  = (w_pos < (L_MIN_EXT + L_STEP_EXT));
        w_at_max  = MAX_EN && ((w_pos + L_SIZE_EXT + L_STEP_EXT) > L_MAX_EXT);
        o_dir     = w_dir_eff;
        o_pos     = i_pos;
        if (w_dir_eff == DIR_NEG) begin
            if (w_at_min) begin
                o_pos = L_MIN_C;
                if (!i_force_flip) begin
                    o_dir = DIR_POS;
                end
            end else begin
                o_pos = w_dec;
            end
        end else begin
            if (!i_force_flip && w_at_max) begin
                o_pos = L_BOUNCE_C;
                o_dir = DIR_NEG;
            end else if (w_inc[COORD_W]) begin
                o_pos = '1;
            end else begin
                o_pos = w_inc[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball motion controller: serves, moves and bounces the ball once per frame,
// freezes it for a hold period after a win, then re-centres it for the next
// serve. All outputs are registered on frame_clk.
module ball_motion
    import pong_pkg::*;
#(
    parameter int unsigned X_START     = 100,
    parameter int unsigned Y_START     = 240,
    parameter int unsigned X_MIN       = SCREEN_X_MIN,
    parameter int unsigned Y_MIN       = SCREEN_Y_MIN,
    parameter int unsigned Y_MAX       = SCREEN_Y_MAX,
    parameter int unsigned BALL_W      = 8,
    parameter int unsigned BALL_H      = 8,
    parameter int unsigned STEP_X      = 2,
    parameter int unsigned STEP_Y      = 1,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               serve,
    input  logic               paddle_hit,
    input  logic               win,
    output logic [COORD_W-1:0] BallX,
    output logic [COORD_W-1:0] BallY,
    output logic [COORD_W-1:0] BallWidth,
    output logic [COORD_W-1:0] BallHeight,
    output logic               moving,
    output logic               score_evt
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_START_C = COORD_W'(Y_START);

    ball_state_t        r_state;
    ball_state_t        w_next_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    dir_t               r_dir_x;
    dir_t               r_dir_y;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_score_evt;
    logic [COORD_W-1:0] w_x_step;
    logic [COORD_W-1:0] w_y_step;
    dir_t               w_dir_x_step;
    dir_t               w_dir_y_step;
    logic               w_hold_done;

    ball_axis_step #(
        .STEP   (STEP_X),
        .MIN    (X_MIN),
        .MAX    (SCREEN_X_MAX),
        .SIZE   (BALL_W),
        .MAX_EN (1'b0)
    ) u_axis_x (
        .i_pos        (r_x),
        .i_dir        (r_dir_x),
        .i_force_flip (paddle_hit),
        .o_pos        (w_x_step),
        .o_dir        (w_dir_x_step)
    );

    ball_axis_step #(
        .STEP   (STEP_Y),
        .MIN    (Y_MIN),
        .MAX    (Y_MAX),
        .SIZE   (BALL_H),
        .MAX_EN (1'b1)
    ) u_axis_y (
        .i_pos        (r_y),
        .i_dir        (r_dir_y),
        .i_force_flip (1'b0),
        .o_pos        (w_y_step),
        .o_dir        (w_dir_y_step)
    );

    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    // State register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; win outranks everything else while moving.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (serve)       w_next_state = ST_MOVE;
            ST_MOVE: if (win)         w_next_state = ST_HOLD;
            ST_HOLD: if (w_hold_done) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Position, direction, hold counter and score pulse.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_x         <= X_START_C;
            r_y         <= Y_START_C;
            r_dir_x     <= DIR_POS;
            r_dir_y     <= DIR_POS;
            r_hold_cnt  <= '0;
            r_score_evt <= 1'b0;
        end else begin
            r_score_evt <= 1'b0;
            case (r_state)
                ST_MOVE: begin
                    if (win) begin
                        r_score_evt <= 1'b1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_x     <= w_x_step;
                        r_y     <= w_y_step;
                        r_dir_x <= w_dir_x_step;
                        r_dir_y <= w_dir_y_step;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_done) begin
                        r_x        <= X_START_C;
                        r_y        <= Y_START_C;
                        r_dir_x    <= DIR_POS;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        moving     = (r_state == ST_MOVE);
        score_evt  = r_score_evt;
        BallX      = r_x;
        BallY      = r_y;
        BallWidth  = COORD_W'(BALL_W);
        BallHeight = COORD_W'(BALL_H);
    end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus randomized
// paddle/serve traffic, compared each frame against a plain-integer model.
module tb_ball_motion;

    localparam int X_START = 100;
    localparam int Y_START = 240;
    localparam int X_MIN   = 0;
    localparam int Y_MIN   = 0;
    localparam int Y_MAX   = 479;
    localparam int BALL_W  = 8;
    localparam int BALL_H  = 8;
    localparam int STEP_X  = 2;
    localparam int STEP_Y  = 1;
    localparam int HOLD_N  = 60;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_HOLD = 2;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       serve = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       win = 1'b0;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallWidth;
    logic [9:0] BallHeight;
    logic       moving;
    logic       score_evt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position, +1/-1 directions, mode, hold frames.
    int mx, my, mdx, mdy, mst, mhc, msc;

    always #5 frame_clk = ~frame_clk;

    ball_motion #(
        .X_START     (X_START),
        .Y_START     (Y_START),
        .X_MIN       (X_MIN),
        .Y_MIN       (Y_MIN),
        .Y_MAX       (Y_MAX),
        .BALL_W      (BALL_W),
        .BALL_H      (BALL_H),
        .STEP_X      (STEP_X),
        .STEP_Y      (STEP_Y),
        .HOLD_FRAMES (HOLD_N)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .serve      (serve),
        .paddle_hit (paddle_hit),
        .win        (win),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallWidth  (BallWidth),
        .BallHeight (BallHeight),
        .moving     (moving),
        .score_evt  (score_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit s, input bit p, input bit w);
        if (rst) begin
            mx = X_START; my = Y_START; mdx = 1; mdy = 1;
            mst = M_IDLE; mhc = 0; msc = 0;
            return;
        end
        msc = 0;
        if (mst == M_IDLE) begin
            if (s) mst = M_MOVE;
        end else if (mst == M_MOVE) begin
            if (w) begin
                mst = M_HOLD; msc = 1; mhc = 0;
            end else begin
                if (p) begin
                    mdx = -mdx; mx = mx + STEP_X * mdx;
                end else if (mdx < 0 && mx < X_MIN + STEP_X) begin
                    mx = X_MIN; mdx = 1;
                end else begin
                    mx = mx + STEP_X * mdx;
                end
                if (mdy > 0 && my + BALL_H + STEP_Y > Y_MAX) begin
                    my = Y_MAX - BALL_H; mdy = -1;
                end else if (mdy < 0 && my < Y_MIN + STEP_Y) begin
                    my = Y_MIN; mdy = 1;
                end else begin
                    my = my + STEP_Y * mdy;
                end
            end
        end else begin
            if (mhc == HOLD_N - 1) begin
                mx = X_START; my = Y_START; mdx = 1; mhc = 0; mst = M_IDLE;
            end else begin
                mhc = mhc + 1;
            end
        end
    endtask

    // One frame: drive inputs, clock, advance the model, compare outputs.
    task automatic step_frame(input bit rst, input bit s, input bit p, input bit w);
        Reset = rst; serve = s; paddle_hit = p; win = w;
        @(posedge frame_clk);
        #1;
        model_step(rst, s, p, w);
        check("frame_x", 32'(BallX), 32'(mx));
        check("frame_y", 32'(BallY), 32'(my));
        check("frame_moving", 32'(moving), 32'(mst == M_MOVE));
        check("frame_score", 32'(score_evt), 32'(msc));
        Reset = 1'b0; serve = 1'b0; paddle_hit = 1'b0; win = 1'b0;
    endtask

    initial begin
        int x0, y0, guard;
        bit p;

        // Reset and idle.
        step_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_x", 32'(BallX), 32'd100);
        check("rst_y", 32'(BallY), 32'd240);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_score", 32'(score_evt), 32'd0);
        check("width", 32'(BallWidth), 32'd8);
        check("height", 32'(BallHeight), 32'd8);
        repeat (5) step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_x", 32'(BallX), 32'd100);
        check("idle_y", 32'(BallY), 32'd240);

        // Serve: moving at once, position changes one frame later.
        step_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check("serve_moving", 32'(moving), 32'd1);
        check("serve_x", 32'(BallX), 32'd100);
        check("serve_y", 32'(BallY), 32'd240);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("first_x", 32'(BallX), 32'd102);
        check("first_y", 32'(BallY), 32'd241);

        // Bottom wall.
        guard = 0;
        while (!(my == 470 && mdy > 0) && guard < 600) begin
            step_frame(1'b0, 1'b0, 1'b0, 1'b0); guard++;
        end
        check("reach_y470", 32'(my == 470), 32'd1);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("bottom_y1", 32'(BallY), 32'd471);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("bottom_y2", 32'(BallY), 32'd471);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("bottom_y3", 32'(BallY), 32'd470);

        // Paddle turns the ball left; then the left wall.
        x0 = mx;
        step_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("paddle_turn_x", 32'(BallX), 32'(x0 - 2));
        guard = 0;
        while (!(mx == 0 && mdx < 0) && guard < 800) begin
            step_frame(1'b0, 1'b0, 1'b0, 1'b0); guard++;
        end
        check("reach_x0", 32'(mx == 0 && mdx < 0), 32'd1);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("left_x1", 32'(BallX), 32'd0);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("left_x2", 32'(BallX), 32'd2);

        // Paddle at X=200 moving right.
        guard = 0;
        while (!(mx == 200 && mdx > 0) && guard < 300) begin
            step_frame(1'b0, 1'b0, 1'b0, 1'b0); guard++;
        end
        check("reach_x200", 32'(mx == 200), 32'd1);
        step_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("paddle_x1", 32'(BallX), 32'd198);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("paddle_x2", 32'(BallX), 32'd196);

        // Steer with the paddle so both axes meet their walls together.
        guard = 0;
        while (!(mx == 0 && my == 0 && mdx < 0 && mdy < 0) && guard < 6000) begin
            p = 1'b0;
            if (mdx > 0 && mx >= 1000) p = 1'b1;
            else if (mdy < 0 && mdx > 0 && mx / 2 == my && mx >= 10) p = 1'b1;
            else if (mdy < 0 && mdx < 0 && mx / 2 != my && mx >= 10) p = 1'b1;
            step_frame(1'b0, 1'b0, p, 1'b0); guard++;
        end
        check("reach_corner", 32'(mx == 0 && my == 0), 32'd1);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("corner_x", 32'(BallX), 32'd0);
        check("corner_y", 32'(BallY), 32'd0);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("corner_next_x", 32'(BallX), 32'd2);
        check("corner_next_y", 32'(BallY), 32'd1);

        // Randomized paddle and serve traffic.
        repeat (400) begin
            p = ($urandom_range(7) == 0) && mx >= 10 && mx < 1000;
            if (mdx > 0 && mx >= 1000) p = 1'b1;
            step_frame(1'b0, 1'($urandom_range(1)), p, 1'b0);
        end

        // Win together with paddle: pulse, freeze, re-centre.
        x0 = mx; y0 = my;
        step_frame(1'b0, 1'b0, 1'b1, 1'b1);
        check("win_score", 32'(score_evt), 32'd1);
        check("win_moving", 32'(moving), 32'd0);
        check("win_x", 32'(BallX), 32'(x0));
        check("win_y", 32'(BallY), 32'(y0));
        for (int i = 1; i < HOLD_N; i++) begin
            step_frame(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
            check("hold_x", 32'(BallX), 32'(x0));
            check("hold_y", 32'(BallY), 32'(y0));
            check("hold_score", 32'(score_evt), 32'd0);
        end
        step_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check("recentre_x", 32'(BallX), 32'd100);
        check("recentre_y", 32'(BallY), 32'd240);
        check("recentre_moving", 32'(moving), 32'd0);

        // Reset in the middle of HOLD.
        step_frame(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        step_frame(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (29) step_frame(1'b0, 1'b1, 1'b0, 1'b0);
        step_frame(1'b1, 1'b1, 1'b1, 1'b1);
        check("hold_rst_x", 32'(BallX), 32'd100);
        check("hold_rst_y", 32'(BallY), 32'd240);
        check("hold_rst_moving", 32'(moving), 32'd0);
        check("hold_rst_score", 32'(score_evt), 32'd0);
        step_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check("reserve_moving", 32'(moving), 32'd1);
        check("reserve_x", 32'(BallX), 32'd100);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("reserve_x2", 32'(BallX), 32'd102);
        check("reserve_y2", 32'(BallY), 32'd241);

        // A fresh win must hold for the full period (counter was cleared).
        repeat (10) step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        x0 = mx;
        step_frame(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (HOLD_N - 1) step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("full_hold_x", 32'(BallX), 32'(x0));
        step_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("full_hold_end_x", 32'(BallX), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
